// File: rtl/ace_snoop_initiator.sv
// ace_snoop_initiator
// Interconnect-side ACE snoop issuer. Each accepted i_start sends one AC snoop and then collects
// the CR response and the CD line beats. The block reports response latencies, timeouts and CD
// protocol errors.
// Ports:
//   ace_aclk, ace_areset           clock, synchronous active-high reset
//   i_start, i_acaddr, i_acsnoop   request pulse with the snoop address and type (captured on start)
//   i_timeout_reg                  cycle limit counted from the AC handshake, 0 = disabled
//   o_acvalid/i_acready, o_acaddr, o_acsnoop, o_acprot   AC channel
//   i_crvalid/o_crready, i_crresp  CR channel
//   i_cdvalid/o_cdready, i_cddata, i_cdlast              CD channel
//   o_busy, o_done                 transaction in flight / one-cycle completion pulse
//   o_crresp, o_line_data          captured response and the collected line (beat k at k*DATA)
//   o_cr_latency, o_cd_latency     cycles from the AC handshake to the CR / last CD handshake
//   o_timeout, o_proto_err         abort by timeout / CD protocol error
module ace_snoop_initiator #(
  parameter int unsigned C_ACE_ADDR_WIDTH = 44,
  parameter int unsigned C_ACE_DATA_WIDTH = 128,
  parameter int unsigned C_LINE_BYTES     = 64
) (
  input  logic                          ace_aclk,
  input  logic                          ace_areset,
  input  logic                          i_start,
  input  logic [C_ACE_ADDR_WIDTH-1:0]   i_acaddr,
  input  logic [3:0]                    i_acsnoop,
  input  logic [31:0]                   i_timeout_reg,
  output logic                          o_acvalid,
  input  logic                          i_acready,
  output logic [C_ACE_ADDR_WIDTH-1:0]   o_acaddr,
  output logic [3:0]                    o_acsnoop,
  output logic [2:0]                    o_acprot,
  input  logic                          i_crvalid,
  output logic                          o_crready,
  input  logic [4:0]                    i_crresp,
  input  logic                          i_cdvalid,
  output logic                          o_cdready,
  input  logic [C_ACE_DATA_WIDTH-1:0]   i_cddata,
  input  logic                          i_cdlast,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [4:0]                    o_crresp,
  output logic [C_LINE_BYTES*8-1:0]     o_line_data,
  output logic [31:0]                   o_cr_latency,
  output logic [31:0]                   o_cd_latency,
  output logic                          o_timeout,
  output logic                          o_proto_err
);

  localparam int unsigned NBEATS = (C_LINE_BYTES * 8) / C_ACE_DATA_WIDTH;
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {S_IDLE, S_AC, S_RESP, S_CD, S_DONE} state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat_cnt;
  logic              cd_closed;
  logic [31:0]       count;

  logic [31:0] cnt_inc;
  logic        in_resp_phase;
  logic        cr_hs;
  logic        cd_hs;
  logic        cd_last_slot;
  logic        cd_close;
  logic        beats_seen;
  logic        cr_to_cd;
  logic        finish_now;
  logic        timeout_hit;

  // Protection is fixed: unprivileged, non-secure, data access.
  assign o_acprot = 3'b010;

  // Handshake decode and completion/timeout decisions for the current cycle.
  always_comb begin
    cnt_inc       = (count == CNT_MAX) ? count : count + 32'd1;
    in_resp_phase = (state == S_RESP) || (state == S_CD);
    cr_hs         = (state == S_RESP) && o_crready && i_crvalid;
    cd_hs         = in_resp_phase && o_cdready && i_cdvalid;
    cd_last_slot  = (beat_cnt == LAST_BEAT);
    // The final slot closes the line even when cdlast is missing.
    cd_close      = cd_hs && (i_cdlast || cd_last_slot);
    beats_seen    = cd_hs || cd_closed || (beat_cnt != '0);
    cr_to_cd      = cr_hs && i_crresp[0] && !cd_closed && !cd_close;
    finish_now    = (cr_hs && !cr_to_cd) || ((state == S_CD) && cd_close);
    // cnt_inc is the elapsed-cycle count at this edge, the same basis as the latencies.
    timeout_hit   = in_resp_phase && (i_timeout_reg != 32'd0) && (cnt_inc == i_timeout_reg);
  end

  // Transaction FSM with registered channel controls and results.
  always_ff @(posedge ace_aclk) begin
    if (ace_areset) begin
      state        <= S_IDLE;
      beat_cnt     <= '0;
      cd_closed    <= 1'b0;
      count        <= '0;
      o_acvalid    <= 1'b0;
      o_acaddr     <= '0;
      o_acsnoop    <= '0;
      o_crready    <= 1'b0;
      o_cdready    <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_crresp     <= '0;
      o_line_data  <= '0;
      o_cr_latency <= '0;
      o_cd_latency <= '0;
      o_timeout    <= 1'b0;
      o_proto_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          o_done <= 1'b0;
          state  <= S_IDLE;
          if (i_start) begin
            o_acaddr     <= i_acaddr;
            o_acsnoop    <= i_acsnoop;
            o_acvalid    <= 1'b1;
            o_busy       <= 1'b1;
            o_crresp     <= '0;
            o_line_data  <= '0;
            o_cr_latency <= '0;
            o_cd_latency <= '0;
            o_timeout    <= 1'b0;
            o_proto_err  <= 1'b0;
            beat_cnt     <= '0;
            cd_closed    <= 1'b0;
            count        <= '0;
            state        <= S_AC;
          end
        end

        S_AC: begin
          if (i_acready) begin
            o_acvalid <= 1'b0;
            count     <= '0;
            o_crready <= 1'b1;
            o_cdready <= 1'b1;
            state     <= S_RESP;
          end
        end

        S_RESP, S_CD: begin
          count <= cnt_inc;

          if (cd_hs) begin
            o_line_data[32'(beat_cnt) * C_ACE_DATA_WIDTH +: C_ACE_DATA_WIDTH] <= i_cddata;
            // cdlast must coincide exactly with the final slot.
            if (i_cdlast != cd_last_slot) begin
              o_proto_err <= 1'b1;
            end
            if (cd_close) begin
              cd_closed    <= 1'b1;
              o_cdready    <= 1'b0;
              o_cd_latency <= cnt_inc;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end

          if (cr_hs) begin
            o_crresp     <= i_crresp;
            o_cr_latency <= cnt_inc;
            o_crready    <= 1'b0;
            // Data arrived although the response says no data transfer.
            if (!i_crresp[0] && beats_seen) begin
              o_proto_err <= 1'b1;
            end
            if (cr_to_cd) begin
              state <= S_CD;
            end
          end

          // A genuine completion wins over a timeout on the same edge.
          if (finish_now || timeout_hit) begin
            if (!finish_now) begin
              o_timeout <= 1'b1;
            end
            o_crready <= 1'b0;
            o_cdready <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            state     <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Directed bench for ace_snoop_initiator: a table of snoop transactions with hand-computed
// results, plus hand-written sequences for reset, mid-transaction reset and start-while-busy.
module tb_ace_snoop_initiator;

  localparam int unsigned AW = 44;
  localparam int unsigned DW = 128;
  localparam int unsigned LW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] acaddr_in;
  logic [3:0]    acsnoop_in;
  logic [31:0]   tmo_reg;
  logic          acvalid;
  logic          acready;
  logic [AW-1:0] acaddr;
  logic [3:0]    acsnoop;
  logic [2:0]    acprot;
  logic          crvalid;
  logic          crready;
  logic [4:0]    crresp_in;
  logic          cdvalid;
  logic          cdready;
  logic [DW-1:0] cddata;
  logic          cdlast;
  logic          busy;
  logic          done;
  logic [4:0]    crresp;
  logic [LW-1:0] line;
  logic [31:0]   cr_lat;
  logic [31:0]   cd_lat;
  logic          tmo;
  logic          perr;

  ace_snoop_initiator dut (
    .ace_aclk      (clk),
    .ace_areset    (rst),
    .i_start       (start),
    .i_acaddr      (acaddr_in),
    .i_acsnoop     (acsnoop_in),
    .i_timeout_reg (tmo_reg),
    .o_acvalid     (acvalid),
    .i_acready     (acready),
    .o_acaddr      (acaddr),
    .o_acsnoop     (acsnoop),
    .o_acprot      (acprot),
    .i_crvalid     (crvalid),
    .o_crready     (crready),
    .i_crresp      (crresp_in),
    .i_cdvalid     (cdvalid),
    .o_cdready     (cdready),
    .i_cddata      (cddata),
    .i_cdlast      (cdlast),
    .o_busy        (busy),
    .o_done        (done),
    .o_crresp      (crresp),
    .o_line_data   (line),
    .o_cr_latency  (cr_lat),
    .o_cd_latency  (cd_lat),
    .o_timeout     (tmo),
    .o_proto_err   (perr)
  );

  always #5 clk = ~clk;

  // One transaction: stimulus timing (edges counted after the AC handshake) and expected results.
  typedef struct {
    logic [3:0]    snoop;
    logic [AW-1:0] addr;
    int            ac_delay;
    int            cr_at;     // 0 = responder never answers
    logic [4:0]    resp;
    int            cd_first;
    int            nbeats;
    int            last_idx;  // beat carrying cdlast, -1 = none
    logic [31:0]   tmo;
    logic [4:0]    e_resp;
    logic [31:0]   e_crlat;
    logic [31:0]   e_cdlat;
    int            e_beats;
    logic          e_perr;
    logic          e_tmo;
    int            e_done;
  } vec_t;

  vec_t vecs[10];
  int   total = 0;
  int   bad   = 0;
  int   cur   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL vec%0d %s: got %0h want %0h", cur, nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int idx, input int b);
    return DW'(idx * 256 + 160 + b);
  endfunction

  task automatic clear_inputs();
    start      = 1'b0;
    acaddr_in  = '0;
    acsnoop_in = '0;
    acready    = 1'b0;
    crvalid    = 1'b0;
    crresp_in  = '0;
    cdvalid    = 1'b0;
    cddata     = '0;
    cdlast     = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_acvalid"}, LW'(acvalid), '0);
    chk({tag, "_crready"}, LW'(crready), '0);
    chk({tag, "_cdready"}, LW'(cdready), '0);
    chk({tag, "_busy"},    LW'(busy),    '0);
    chk({tag, "_done"},    LW'(done),    '0);
    chk({tag, "_acaddr"},  LW'(acaddr),  '0);
    chk({tag, "_acsnoop"}, LW'(acsnoop), '0);
    chk({tag, "_crresp"},  LW'(crresp),  '0);
    chk({tag, "_line"},    line,         '0);
    chk({tag, "_crlat"},   LW'(cr_lat),  '0);
    chk({tag, "_cdlat"},   LW'(cd_lat),  '0);
    chk({tag, "_tmo"},     LW'(tmo),     '0);
    chk({tag, "_perr"},    LW'(perr),    '0);
    chk({tag, "_acprot"},  LW'(acprot),  LW'(3'b010));
  endtask

  // Drives one table entry; poke > 0 pulses i_start (with a bogus address) at that edge.
  task automatic run_vec(input vec_t v, input int idx, input int poke);
    int            done_k;
    int            b;
    logic [LW-1:0] exp_line;
    cur        = idx;
    acaddr_in  = v.addr;
    acsnoop_in = v.snoop;
    tmo_reg    = v.tmo;
    start      = 1'b1;
    tick();
    clear_inputs();
    chk("acvalid_rise", LW'(acvalid), LW'(1'b1));
    chk("busy_set",     LW'(busy),    LW'(1'b1));
    chk("acaddr",       LW'(acaddr),  LW'(v.addr));
    chk("acsnoop",      LW'(acsnoop), LW'(v.snoop));
    for (int d = 0; d < v.ac_delay; d++) begin
      tick();
      chk("acvalid_hold", LW'(acvalid), LW'(1'b1));
    end
    acready = 1'b1;
    tick();
    acready = 1'b0;
    chk("acvalid_drop", LW'(acvalid), '0);
    chk("readies_up",   LW'({crready, cdready}), LW'(2'b11));

    done_k = 0;
    for (int k = 1; k <= 200; k++) begin
      crvalid   = (v.cr_at != 0) && (k == v.cr_at);
      crresp_in = crvalid ? v.resp : 5'h00;
      if (v.nbeats > 0 && k >= v.cd_first && k < v.cd_first + v.nbeats) begin
        b       = k - v.cd_first;
        cdvalid = 1'b1;
        cddata  = beat_data(idx, b);
        cdlast  = (b == v.last_idx);
      end else begin
        cdvalid = 1'b0;
        cddata  = '0;
        cdlast  = 1'b0;
      end
      if (poke != 0 && k == poke) begin
        start     = 1'b1;
        acaddr_in = AW'(44'hDEAD);
      end else begin
        start     = 1'b0;
        acaddr_in = '0;
      end
      tick();
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    clear_inputs();

    exp_line = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < v.e_beats) exp_line[i*DW +: DW] = beat_data(idx, i);
    end
    chk("done_edge",  LW'(done_k), LW'(v.e_done));
    chk("busy_clear", LW'(busy),   '0);
    chk("crresp",     LW'(crresp), LW'(v.e_resp));
    chk("cr_latency", LW'(cr_lat), LW'(v.e_crlat));
    chk("cd_latency", LW'(cd_lat), LW'(v.e_cdlat));
    chk("line",       line,        exp_line);
    chk("proto_err",  LW'(perr),   LW'(v.e_perr));
    chk("timeout",    LW'(tmo),    LW'(v.e_tmo));
    chk("readies_low", LW'({crready, cdready}), '0);
    chk("acaddr_kept", LW'(acaddr), LW'(v.addr));
    tick();
    chk("done_pulse", LW'(done),    '0);
    chk("no_restart", LW'(acvalid), '0);
    chk("crresp_held", LW'(crresp), LW'(v.e_resp));
    chk("line_held",   line,        exp_line);
    tick();
  endtask

  initial begin
    // snoop addr acdly cr_at resp cd_first nbeats last tmo | e_resp e_crlat e_cdlat e_beats e_perr e_tmo e_done
    vecs[0] = '{4'h1, 44'h1000, 2, 3, 5'h01, 4, 4,  3,  0, 5'h01,  3, 7, 4, 1'b0, 1'b0,  7};
    vecs[1] = '{4'h7, 44'h2040, 0, 5, 5'h00, 0, 0, -1,  0, 5'h00,  5, 0, 0, 1'b0, 1'b0,  5};
    vecs[2] = '{4'hB, 44'h3000, 1, 5, 5'h01, 1, 4,  3,  0, 5'h01,  5, 4, 4, 1'b0, 1'b0,  5};
    vecs[3] = '{4'h2, 44'h4000, 0, 0, 5'h00, 0, 0, -1, 50, 5'h00,  0, 0, 0, 1'b0, 1'b1, 50};
    vecs[4] = '{4'h1, 44'h5000, 0, 3, 5'h01, 4, 2,  1,  0, 5'h01,  3, 5, 2, 1'b1, 1'b0,  5};
    vecs[5] = '{4'h1, 44'h6000, 1, 3, 5'h01, 4, 4, -1,  0, 5'h01,  3, 7, 4, 1'b1, 1'b0,  7};
    vecs[6] = '{4'h3, 44'h7000, 0, 4, 5'h00, 1, 2, -1,  0, 5'h00,  4, 0, 2, 1'b1, 1'b0,  4};
    vecs[7] = '{4'h9, 44'h8000, 0, 3, 5'h02, 0, 0, -1,  3, 5'h02,  3, 0, 0, 1'b0, 1'b0,  3};
    vecs[8] = '{4'h1, 44'h9000, 0, 4, 5'h01, 1, 4,  3,  0, 5'h01,  4, 4, 4, 1'b0, 1'b0,  4};
    vecs[9] = '{4'h1, 44'hA000, 0, 2, 5'h01, 3, 1, -1, 10, 5'h01,  2, 0, 1, 1'b0, 1'b1, 10};

    clear_inputs();
    tmo_reg = '0;
    rst     = 1'b1;
    tick();
    tick();
    cur = -1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i, 0);
    end

    // Start pulse while busy must be dropped, not queued.
    run_vec(vecs[1], 1, 2);

    // Reset while collecting CD beats.
    cur        = 20;
    acaddr_in  = 44'hBEEF;
    acsnoop_in = 4'h1;
    tmo_reg    = '0;
    start      = 1'b1;
    tick();
    clear_inputs();
    acready = 1'b1;
    tick();
    acready = 1'b0;
    tick();
    crvalid   = 1'b1;
    crresp_in = 5'h01;
    tick();
    clear_inputs();
    cdvalid = 1'b1;
    cddata  = 128'h55;
    tick();
    clear_inputs();
    chk("in_cd_busy", LW'({busy, cdready, crready}), LW'(3'b110));
    rst = 1'b1;
    tick();
    chk_all_zero("midreset");
    rst = 1'b0;
    tick();
    run_vec(vecs[0], 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
